// File: rtl/eth_rx_s2mm_gate.sv
// Gates the RX data/status AXI-Stream pair into the S2MM DMA. The status length word is rewritten with the counted byte length.
// One register stage per output stream; status framing errors are truncated and the remainder of the status frame is drained.
module eth_rx_s2mm_gate #(
  parameter int unsigned C_STS_WORDS = 6,
  parameter int unsigned C_LEN_WORD  = 5
) (
  input  logic        s2mm_clk,
  input  logic        s2mm_resetn,
  input  logic [63:0] rxd_tdata,
  input  logic [7:0]  rxd_tkeep,
  input  logic        rxd_tlast,
  input  logic        rxd_tvalid,
  output logic        rxd_tready,
  input  logic [31:0] rxs_tdata,
  input  logic [3:0]  rxs_tkeep,
  input  logic        rxs_tlast,
  input  logic        rxs_tvalid,
  output logic        rxs_tready,
  output logic [63:0] s2mm_d_tdata,
  output logic [7:0]  s2mm_d_tkeep,
  output logic        s2mm_d_tlast,
  output logic        s2mm_d_tvalid,
  input  logic        s2mm_d_tready,
  output logic [31:0] s2mm_s_tdata,
  output logic [3:0]  s2mm_s_tkeep,
  output logic        s2mm_s_tlast,
  output logic        s2mm_s_tvalid,
  input  logic        s2mm_s_tready,
  output logic [31:0] frm_cnt,
  output logic [15:0] len_err_cnt,
  output logic [15:0] sts_err_cnt,
  output logic [3:0]  gate_fsm_dbg
);

  typedef enum logic [1:0] {ST_DATA = 2'd0, ST_STS = 2'd1, ST_DROP = 2'd2} state_t;

  localparam logic [2:0] LEN_IDX  = 3'(C_LEN_WORD);
  localparam logic [2:0] LAST_IDX = 3'(C_STS_WORDS - 1);

  state_t      state_q, state_d;
  logic        rdy_en_q;
  logic [63:0] d_dat_q, d_dat_d;
  logic [7:0]  d_keep_q, d_keep_d;
  logic        d_last_q, d_last_d;
  logic        d_vld_q, d_vld_d;
  logic [31:0] s_dat_q, s_dat_d;
  logic [3:0]  s_keep_q, s_keep_d;
  logic        s_last_q, s_last_d;
  logic        s_vld_q, s_vld_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] len_err_q, len_err_d;
  logic [15:0] sts_err_q, sts_err_d;

  logic        rxd_acc, rxs_acc;
  logic [3:0]  keep_pop;
  logic [16:0] byte_sum;
  logic [15:0] byte_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // rdy_en_q holds both readies low until the first edge after reset release.
  assign rxd_tready = rdy_en_q && (state_q == ST_DATA) && (!d_vld_q || s2mm_d_tready);
  assign rxs_tready = rdy_en_q && (((state_q == ST_STS) && (!s_vld_q || s2mm_s_tready)) ||
                                   (state_q == ST_DROP));
  assign rxd_acc    = rxd_tvalid && rxd_tready;
  assign rxs_acc    = rxs_tvalid && rxs_tready;

  always_comb begin
    keep_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      keep_pop = keep_pop + {3'd0, rxd_tkeep[i]};
    end
    byte_sum = {1'b0, byte_cnt_q} + {13'd0, keep_pop};
    byte_nxt = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  end

  always_comb begin
    state_d    = state_q;
    d_dat_d    = d_dat_q;
    d_keep_d   = d_keep_q;
    d_last_d   = d_last_q;
    d_vld_d    = d_vld_q;
    s_dat_d    = s_dat_q;
    s_keep_d   = s_keep_q;
    s_last_d   = s_last_q;
    s_vld_d    = s_vld_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    frm_cnt_d  = frm_cnt_q;
    len_err_d  = len_err_q;
    sts_err_d  = sts_err_q;

    if (rxd_acc) begin
      d_dat_d  = rxd_tdata;
      d_keep_d = rxd_tkeep;
      d_last_d = rxd_tlast;
      d_vld_d  = 1'b1;
    end else if (s2mm_d_tready) begin
      d_vld_d = 1'b0;
    end

    if (s2mm_s_tready) begin
      s_vld_d = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (rxd_acc) begin
          if (rxd_tlast) begin
            len_d      = byte_nxt;
            byte_cnt_d = 16'd0;
            frm_cnt_d  = frm_cnt_q + 32'd1;
            idx_d      = 3'd0;
            state_d    = ST_STS;
          end else begin
            byte_cnt_d = byte_nxt;
          end
        end
      end
      ST_STS: begin
        if (rxs_acc) begin
          s_vld_d  = 1'b1;
          s_dat_d  = rxs_tdata;
          s_keep_d = rxs_tkeep;
          s_last_d = 1'b0;
          idx_d    = idx_q + 3'd1;
          if (idx_q == LEN_IDX) begin
            s_dat_d[15:0] = len_q;
            if (rxs_tdata[15:0] != len_q) begin
              len_err_d = sat_inc(len_err_q);
            end
          end
          if (rxs_tlast) begin
            s_last_d = 1'b1;
            state_d  = ST_DATA;
            if (idx_q != LAST_IDX) begin
              sts_err_d = sat_inc(sts_err_q);
            end
          end else if (idx_q == LAST_IDX) begin
            // Overlong status frame: close it here and swallow the rest.
            s_last_d  = 1'b1;
            sts_err_d = sat_inc(sts_err_q);
            state_d   = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (rxs_acc && rxs_tlast) begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      state_q    <= ST_DATA;
      rdy_en_q   <= 1'b0;
      d_dat_q    <= 64'd0;
      d_keep_q   <= 8'd0;
      d_last_q   <= 1'b0;
      d_vld_q    <= 1'b0;
      s_dat_q    <= 32'd0;
      s_keep_q   <= 4'd0;
      s_last_q   <= 1'b0;
      s_vld_q    <= 1'b0;
      byte_cnt_q <= 16'd0;
      len_q      <= 16'd0;
      idx_q      <= 3'd0;
      frm_cnt_q  <= 32'd0;
      len_err_q  <= 16'd0;
      sts_err_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      d_dat_q    <= d_dat_d;
      d_keep_q   <= d_keep_d;
      d_last_q   <= d_last_d;
      d_vld_q    <= d_vld_d;
      s_dat_q    <= s_dat_d;
      s_keep_q   <= s_keep_d;
      s_last_q   <= s_last_d;
      s_vld_q    <= s_vld_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      frm_cnt_q  <= frm_cnt_d;
      len_err_q  <= len_err_d;
      sts_err_q  <= sts_err_d;
    end
  end

  assign s2mm_d_tdata  = d_dat_q;
  assign s2mm_d_tkeep  = d_keep_q;
  assign s2mm_d_tlast  = d_last_q;
  assign s2mm_d_tvalid = d_vld_q;
  assign s2mm_s_tdata  = s_dat_q;
  assign s2mm_s_tkeep  = s_keep_q;
  assign s2mm_s_tlast  = s_last_q;
  assign s2mm_s_tvalid = s_vld_q;
  assign frm_cnt       = frm_cnt_q;
  assign len_err_cnt   = len_err_q;
  assign sts_err_cnt   = sts_err_q;
  assign gate_fsm_dbg  = {2'b00, state_q};

endmodule
